drive_ramp_sequencer: RTL and testbench

- Controller that sequences the two PWM duty-control words (left/right) and H-bridge direction bits from the 2-bit drive command pins.
- Sits between the command input path and the two pwm_simple channels.
- Slews duty in steps, aligned to PWM period boundaries.
- Enforces ramp-down plus zero-duty dwell before any direction reversal.

---
 rtl/drive_ramp_sequencer_pkg.sv | 26 ++
 rtl/drive_ramp_sequencer_channel.sv | 129 ++++++++++++
 rtl/drive_ramp_sequencer.sv | 123 ++++++++++++
 tb/tb_drive_ramp_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/drive_ramp_sequencer_pkg.sv
// Shared types and constants for the drive ramp sequencer.
// Command encodings, direction constants, channel state enum.
package drive_ramp_sequencer_pkg;

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_FWD   = 2'b11;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN,
        ST_DWELL
    } ch_state_e;

    // Counter width for n states; never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/drive_ramp_sequencer_channel.sv
// One H-bridge channel: slews duty on ticks, dwells at zero before a flip.
// Ports: clk_out, rst (async low), tick, target, req_dir -> duty, dir, ch_busy.
module drive_ramp_channel
    import drive_ramp_sequencer_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int STEP_PERIODS  = 2,
    parameter int DWELL_PERIODS = 4,
    parameter int MAX_DUTY      = 7
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] target,
    input  logic             req_dir,
    output logic [WIDTH-1:0] duty,
    output logic             dir,
    output logic             ch_busy
);

    localparam int SW = cnt_width(STEP_PERIODS);
    localparam int DW = cnt_width(DWELL_PERIODS + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_PERIODS - 1);
    localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(MAX_DUTY);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             dir_q, dir_d;
    logic [SW-1:0]    step_q, step_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [WIDTH-1:0] tgt_sat;
    logic [WIDTH-1:0] goal;

    always_comb begin
        tgt_sat = (target >= DUTY_MAX) ? DUTY_MAX : target;
        // A pending reversal means the duty must first come down to zero.
        goal    = (req_dir == dir_q) ? tgt_sat : '0;
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_dir != dir_q) begin
                        state_d = ST_DWELL;
                        dwell_d = '0;
                    end else if (goal != '0) begin
                        state_d = ST_RAMP_UP;
                    end
                end
                ST_RUN: begin
                    if (goal > duty_q) begin
                        state_d = ST_RAMP_UP;
                    end else if (goal < duty_q) begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    // Slew direction follows the live goal; the step
                    // counter keeps its phase across retargets.
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (goal > duty_q) begin
                            duty_d = duty_q + 1'b1;
                        end else if (goal < duty_q) begin
                            duty_d = duty_q - 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                    if (duty_d == goal) begin
                        step_d = '0;
                        if (goal != '0) begin
                            state_d = ST_RUN;
                        end else if (req_dir != dir_q) begin
                            state_d = ST_DWELL;
                            dwell_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (goal > duty_d) begin
                        state_d = ST_RAMP_UP;
                    end else begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
                ST_DWELL: begin
                    // Dwell always runs to completion; the flip takes
                    // whatever direction is requested at its end.
                    if (dwell_q == DWELL_LAST) begin
                        dir_d   = req_dir;
                        state_d = (tgt_sat != '0) ? ST_RAMP_UP : ST_IDLE;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            dir_q   <= DIR_FWD;
            step_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
        end
    end

    assign duty    = duty_q;
    assign dir     = dir_q;
    assign ch_busy = (state_q == ST_RAMP_UP) ||
                     (state_q == ST_RAMP_DOWN) ||
                     (state_q == ST_DWELL);

endmodule

// File: rtl/drive_ramp_sequencer.sv
// Drive ramp sequencer: command sync/qualify, PWM tick, two ramp channels.
// Ports: clk_out, rst (async low), trigger, cmd -> lduty, rduty, ldir, rdir, busy.
module drive_ramp_sequencer
    import drive_ramp_sequencer_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int STEP_PERIODS  = 2,
    parameter int DWELL_PERIODS = 4,
    parameter int MAX_DUTY      = 7
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic [WIDTH-1:0] trigger,
    input  logic [1:0]       cmd,
    output logic [WIDTH-1:0] lduty,
    output logic [WIDTH-1:0] rduty,
    output logic             ldir,
    output logic             rdir,
    output logic             busy
);

    localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(MAX_DUTY);

    logic [1:0]       cmd_meta_q, cmd_meta_d;
    logic [1:0]       cmd_sync_q, cmd_sync_d;
    logic [1:0]       samp_q, samp_d;
    logic [1:0]       acc_q, acc_d;
    logic             ones_q, ones_d;
    logic             tick;
    logic [WIDTH-1:0] l_target, r_target;
    logic             l_req, r_req;
    logic             l_busy, r_busy;

    always_comb begin
        cmd_meta_d = cmd;
        cmd_sync_d = cmd_meta_q;
        ones_d     = &trigger;
        // Edge-qualified so a counter stalled at all-ones ticks once.
        tick       = (&trigger) && !ones_q;
        samp_d     = samp_q;
        acc_d      = acc_q;
        if (tick) begin
            samp_d = cmd_sync_q;
            if ((cmd_sync_q == samp_q) && (cmd_sync_q != acc_q)) begin
                acc_d = cmd_sync_q;
            end
        end
    end

    always_comb begin
        l_target = DUTY_MAX;
        r_target = DUTY_MAX;
        l_req    = DIR_FWD;
        r_req    = DIR_FWD;
        unique case (acc_q)
            CMD_FWD: begin
            end
            CMD_LEFT: begin
                l_req = DIR_REV;
            end
            CMD_RIGHT: begin
                r_req = DIR_REV;
            end
            CMD_STOP: begin
                l_target = '0;
                r_target = '0;
                l_req    = ldir;
                r_req    = rdir;
            end
        endcase
    end

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            cmd_meta_q <= CMD_STOP;
            cmd_sync_q <= CMD_STOP;
            samp_q     <= CMD_STOP;
            acc_q      <= CMD_STOP;
            ones_q     <= 1'b0;
        end else begin
            cmd_meta_q <= cmd_meta_d;
            cmd_sync_q <= cmd_sync_d;
            samp_q     <= samp_d;
            acc_q      <= acc_d;
            ones_q     <= ones_d;
        end
    end

    drive_ramp_channel #(
        .WIDTH         (WIDTH),
        .STEP_PERIODS  (STEP_PERIODS),
        .DWELL_PERIODS (DWELL_PERIODS),
        .MAX_DUTY      (MAX_DUTY)
    ) u_left (
        .clk_out (clk_out),
        .rst     (rst),
        .tick    (tick),
        .target  (l_target),
        .req_dir (l_req),
        .duty    (lduty),
        .dir     (ldir),
        .ch_busy (l_busy)
    );

    drive_ramp_channel #(
        .WIDTH         (WIDTH),
        .STEP_PERIODS  (STEP_PERIODS),
        .DWELL_PERIODS (DWELL_PERIODS),
        .MAX_DUTY      (MAX_DUTY)
    ) u_right (
        .clk_out (clk_out),
        .rst     (rst),
        .tick    (tick),
        .target  (r_target),
        .req_dir (r_req),
        .duty    (rduty),
        .dir     (rdir),
        .ch_busy (r_busy)
    );

    assign busy = l_busy | r_busy;

endmodule

// File: tb/tb_drive_ramp_sequencer.sv
// Testbench for drive_ramp_sequencer: table vectors, corner sequences,
// and randomized commands against a per-tick behavioural model.
module tb_drive_ramp_sequencer;

    localparam int STEP  = 2;
    localparam int DWELL = 4;
    localparam int MAXD  = 7;

    logic       clk_out = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] trigger = 3'd0;
    logic [1:0] cmd = 2'b00;
    logic [2:0] lduty, rduty;
    logic       ldir, rdir, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_out = ~clk_out;

    drive_ramp_sequencer dut (
        .clk_out (clk_out),
        .rst     (rst),
        .trigger (trigger),
        .cmd     (cmd),
        .lduty   (lduty),
        .rduty   (rduty),
        .ldir    (ldir),
        .rdir    (rdir),
        .busy    (busy)
    );

    // Model state, one update per PWM period boundary.
    int         m_duty [2];
    int         m_dir  [2];
    int         m_cnt  [2];
    int         m_dwell[2];
    bit         m_slew [2];
    logic [1:0] m_prev;
    logic [1:0] m_acc;

    typedef struct {
        logic [1:0] cmd;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[18];
    int   fwd_d[18] = '{0,0,0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7};
    int   fwd_b[18] = '{0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};

    function automatic logic [8:0] dut_vec();
        return {lduty, rduty, ldir, rdir, busy};
    endfunction

    function automatic logic [8:0] m_vec();
        logic b;
        b = m_slew[0] || m_slew[1] || (m_dwell[0] > 0) || (m_dwell[1] > 0);
        return {3'(m_duty[0]), 3'(m_duty[1]), 1'(m_dir[0]), 1'(m_dir[1]), b};
    endfunction

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %b want %b (ld,rd,ldir,rdir,busy)",
                     name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            m_duty[c]  = 0;
            m_dir[c]   = 1;
            m_cnt[c]   = 0;
            m_dwell[c] = 0;
            m_slew[c]  = 0;
        end
        m_prev = 2'b00;
        m_acc  = 2'b00;
    endtask

    task automatic m_chan(input int c, input int tgt, input int rd);
        int goal;
        if (m_dwell[c] > 0) begin
            m_dwell[c]--;
            if (m_dwell[c] == 0) begin
                m_dir[c]  = rd;
                m_slew[c] = (tgt > 0);
                m_cnt[c]  = 0;
            end
            return;
        end
        goal = (rd == m_dir[c]) ? tgt : 0;
        if (!m_slew[c]) begin
            if (m_duty[c] == 0 && rd != m_dir[c]) begin
                m_dwell[c] = DWELL;
            end else if (goal != m_duty[c]) begin
                m_slew[c] = 1;
                m_cnt[c]  = 0;
            end
        end else begin
            m_cnt[c]++;
            if (m_cnt[c] == STEP) begin
                m_cnt[c] = 0;
                if (goal > m_duty[c]) m_duty[c]++;
                else if (goal < m_duty[c]) m_duty[c]--;
            end
            if (m_duty[c] == goal) begin
                m_slew[c] = 0;
                m_cnt[c]  = 0;
                if (goal == 0 && rd != m_dir[c]) m_dwell[c] = DWELL;
            end
        end
    endtask

    task automatic m_tick(input logic [1:0] s);
        int lt, rt, ld, rd;
        lt = MAXD; rt = MAXD; ld = 1; rd = 1;
        case (m_acc)
            2'b01:   ld = 0;
            2'b10:   rd = 0;
            2'b00: begin
                lt = 0; rt = 0; ld = m_dir[0]; rd = m_dir[1];
            end
            default: ;
        endcase
        m_chan(0, lt, ld);
        m_chan(1, rt, rd);
        if (s == m_prev && s != m_acc) m_acc = s;
        m_prev = s;
    endtask

    // One PWM period: trigger 0..7 then optional stall at 7.
    task automatic run_period(input logic [1:0] c, input int stall);
        for (int i = 0; i < 8 + stall; i++) begin
            @(negedge clk_out);
            check("cycle", dut_vec(), m_vec());
            trigger = (i < 8) ? 3'(i) : 3'd7;
            if (i == 2) cmd = c;
            if (i == 7) m_tick(c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_out);
        rst = 1'b0;
        trigger = 3'd0;
        cmd = 2'($urandom);
        #1 check("reset_async", dut_vec(), 9'b000_000_1_1_0);
        m_reset();
        repeat (3) begin
            @(negedge clk_out);
            check("reset_hold", dut_vec(), 9'b000_000_1_1_0);
        end
        @(negedge clk_out);
        trigger = 3'd0;
        rst = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 18; p++) begin
            tbl[p].cmd = 2'b11;
            tbl[p].exp = {3'(fwd_d[p]), 3'(fwd_d[p]), 1'b1, 1'b1, 1'(fwd_b[p])};
        end
        m_reset();

        // Forward from idle, checked per period from the table.
        do_reset();
        for (int p = 0; p < 18; p++) begin
            run_period(tbl[p].cmd, 0);
            @(posedge clk_out);
            #1 check("fwd_table", dut_vec(), tbl[p].exp);
        end

        // Reversal of the left channel from full forward.
        repeat (40) run_period(2'b01, 0);
        check("reversal_end", dut_vec(), 9'b111_111_0_1_0);

        // Single-period glitch must never be accepted.
        do_reset();
        run_period(2'b11, 0);
        repeat (6) run_period(2'b00, 0);
        check("glitch", dut_vec(), 9'b000_000_1_1_0);

        // Stop while ramping up.
        do_reset();
        repeat (10) run_period(2'b11, 0);
        check("stop_at3", dut_vec(), 9'b011_011_1_1_1);
        repeat (30) run_period(2'b00, 0);
        check("stop_end", dut_vec(), 9'b000_000_1_1_0);

        // Stalled trigger gives exactly one tick per period.
        do_reset();
        repeat (10) run_period(2'b11, 3);
        check("stall", dut_vec(), 9'b011_011_1_1_1);

        // Asynchronous reset mid-period at duty 4.
        do_reset();
        repeat (12) run_period(2'b11, 0);
        @(negedge clk_out);
        trigger = 3'd0;
        @(negedge clk_out);
        trigger = 3'd1;
        check("pre_reset", dut_vec(), 9'b100_100_1_1_1);
        #2 rst = 1'b0;
        #1 check("mid_reset", dut_vec(), 9'b000_000_1_1_0);
        m_reset();
        repeat (3) begin
            @(negedge clk_out);
            check("mid_reset_hold", dut_vec(), 9'b000_000_1_1_0);
        end
        @(negedge clk_out);
        trigger = 3'd0;
        rst = 1'b1;
        repeat (18) run_period(2'b11, 0);
        check("after_reset", dut_vec(), 9'b111_111_1_1_0);

        // Randomized command sequences.
        do_reset();
        for (int k = 0; k < 150; k++) begin
            logic [1:0] c;
            int hold;
            c = 2'($urandom);
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) begin
                run_period(c, ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
